fetch_unit: RTL and testbench

- Instruction fetch stage; sits directly upstream of the decision unit.
- Owns the program counter and fetches the opcode word from memory over a req/ack handshake.
- For jump opcodes (0x14–0x24 in bits [15:8]) it also fetches the following target word.
- Presents program_counter_address, instruction and peek_jump_address, then loads the PC from the decision unit's new_address when the instruction retires.

---
 rtl/fetch_unit.sv | 210 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Owns the program counter, reads the opcode word over
// a req/ack memory handshake and, for jump opcodes (bits [15:8] in 0x14..0x24),
// also reads the following target word. The instruction is then held until the
// execute stage retires it, when the PC is loaded from the decision unit.
//
// Optional feature macro: FETCH_ALIGN_FAULT_EN
//   defined   : odd new_address on retire parks the unit in FAULT and raises
//               align_fault until rst.
//   undefined : bit 0 of new_address is silently cleared.
//
// Ports
//   clk                      in   system clock, rising edge
//   rst                      in   asynchronous active-high reset
//   mem_req                  out  memory read request (registered)
//   mem_addr                 out  memory read byte address (registered)
//   mem_ack                  in   read data valid, completes the request
//   mem_rdata                in   read data, sampled when mem_ack=1
//   instr_valid              out  instruction outputs valid and stable
//   instruction              out  current opcode word
//   peek_jump_address        out  jump target word, 0 for non-jumps
//   program_counter_address  out  byte address of last word of instruction
//   advance                  in   execute stage retires the instruction
//   new_address              in   next PC from the decision unit
//   align_fault              out  (FETCH_ALIGN_FAULT_EN only) misaligned PC
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int                   WORD_SIZE    = 16,
    parameter logic [WORD_SIZE-1:0] RESET_VECTOR = {WORD_SIZE{1'b0}}
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 mem_req,
    output logic [WORD_SIZE-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instruction,
    output logic [WORD_SIZE-1:0] peek_jump_address,
    output logic [WORD_SIZE-1:0] program_counter_address,
    input  logic                 advance,
    input  logic [WORD_SIZE-1:0] new_address
`ifdef FETCH_ALIGN_FAULT_EN
    ,
    output logic                 align_fault
`endif
);

`ifdef FETCH_ALIGN_FAULT_EN
    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_TGT = 2'd1,
        READY     = 2'd2,
        FAULT     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        FETCH_OP  = 2'd0,
        FETCH_TGT = 2'd1,
        READY     = 2'd2
    } state_t;
`endif

    // Jump opcodes carry a second word holding the target address.
    function automatic logic is_jump(input logic [7:0] opcode);
        return (opcode >= 8'h14) && (opcode <= 8'h24);
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [WORD_SIZE-1:0]   pc_r;
    logic [WORD_SIZE-1:0]   pc_nxt_s;
    logic [WORD_SIZE-1:0]   pc_plus2_s;
    logic [WORD_SIZE-1:0]   new_pc_s;
    logic                   mem_req_nxt_s;
    logic [WORD_SIZE-1:0]   mem_addr_nxt_s;
    logic                   valid_nxt_s;
    logic [WORD_SIZE-1:0]   instruction_nxt_s;
    logic [WORD_SIZE-1:0]   peek_nxt_s;
    logic [WORD_SIZE-1:0]   pca_nxt_s;
`ifdef FETCH_ALIGN_FAULT_EN
    logic                   fault_nxt_s;
`endif

    // Target word address; wraps modulo 2^WORD_SIZE.
    assign pc_plus2_s = pc_r + WORD_SIZE'(2);
    // Byte addresses of words are always even.
    assign new_pc_s   = new_address & ~WORD_SIZE'(1);

    // Next-state and next-output logic for the fetch sequencer.
    always_comb begin
        state_nxt_s       = state_r;
        pc_nxt_s          = pc_r;
        mem_req_nxt_s     = mem_req;
        mem_addr_nxt_s    = mem_addr;
        valid_nxt_s       = instr_valid;
        instruction_nxt_s = instruction;
        peek_nxt_s        = peek_jump_address;
        pca_nxt_s         = program_counter_address;
`ifdef FETCH_ALIGN_FAULT_EN
        fault_nxt_s       = align_fault;
`endif
        case (state_r)
            FETCH_OP: begin
                if (!mem_req) begin
                    // First cycle after reset: issue the opcode request.
                    mem_req_nxt_s  = 1'b1;
                    mem_addr_nxt_s = pc_r;
                end else if (mem_ack) begin
                    instruction_nxt_s = mem_rdata;
                    if (is_jump(mem_rdata[15:8])) begin
                        // Back-to-back request for the target word.
                        state_nxt_s    = FETCH_TGT;
                        mem_req_nxt_s  = 1'b1;
                        mem_addr_nxt_s = pc_plus2_s;
                    end else begin
                        state_nxt_s   = READY;
                        mem_req_nxt_s = 1'b0;
                        peek_nxt_s    = {WORD_SIZE{1'b0}};
                        pca_nxt_s     = pc_r;
                        valid_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = FETCH_OP;
                end
            end
            FETCH_TGT: begin
                if (mem_ack) begin
                    state_nxt_s   = READY;
                    mem_req_nxt_s = 1'b0;
                    peek_nxt_s    = mem_rdata;
                    pca_nxt_s     = pc_plus2_s;
                    valid_nxt_s   = 1'b1;
                end else begin
                    state_nxt_s = FETCH_TGT;
                end
            end
            READY: begin
                if (advance) begin
`ifdef FETCH_ALIGN_FAULT_EN
                    if (new_address[0]) begin
                        state_nxt_s   = FAULT;
                        fault_nxt_s   = 1'b1;
                        valid_nxt_s   = 1'b0;
                        mem_req_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s    = FETCH_OP;
                        pc_nxt_s       = new_pc_s;
                        valid_nxt_s    = 1'b0;
                        mem_req_nxt_s  = 1'b1;
                        mem_addr_nxt_s = new_pc_s;
                    end
`else
                    state_nxt_s    = FETCH_OP;
                    pc_nxt_s       = new_pc_s;
                    valid_nxt_s    = 1'b0;
                    mem_req_nxt_s  = 1'b1;
                    mem_addr_nxt_s = new_pc_s;
`endif
                end else begin
                    state_nxt_s = READY;
                end
            end
`ifdef FETCH_ALIGN_FAULT_EN
            FAULT: begin
                // Sticky until rst.
                state_nxt_s   = FAULT;
                mem_req_nxt_s = 1'b0;
                valid_nxt_s   = 1'b0;
            end
`endif
            default: begin
                state_nxt_s   = FETCH_OP;
                mem_req_nxt_s = 1'b0;
                valid_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, PC and registered output flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r                 <= FETCH_OP;
            pc_r                    <= RESET_VECTOR;
            mem_req                 <= 1'b0;
            mem_addr                <= {WORD_SIZE{1'b0}};
            instr_valid             <= 1'b0;
            instruction             <= {WORD_SIZE{1'b0}};
            peek_jump_address       <= {WORD_SIZE{1'b0}};
            program_counter_address <= {WORD_SIZE{1'b0}};
`ifdef FETCH_ALIGN_FAULT_EN
            align_fault             <= 1'b0;
`endif
        end else begin
            state_r                 <= state_nxt_s;
            pc_r                    <= pc_nxt_s;
            mem_req                 <= mem_req_nxt_s;
            mem_addr                <= mem_addr_nxt_s;
            instr_valid             <= valid_nxt_s;
            instruction             <= instruction_nxt_s;
            peek_jump_address       <= peek_nxt_s;
            program_counter_address <= pca_nxt_s;
`ifdef FETCH_ALIGN_FAULT_EN
            align_fault             <= fault_nxt_s;
`endif
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit. A word-array memory with a programmable
// number of wait cycles answers requests; expected instruction fields, request
// address sequences and latencies are derived from the opcode/target rules.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instruction;
    logic [15:0] peek_jump_address;
    logic [15:0] program_counter_address;
    logic        advance = 1'b0;
    logic [15:0] new_address = 16'h0000;
`ifdef FETCH_ALIGN_FAULT_EN
    logic        align_fault;
`endif

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit #(.WORD_SIZE(16), .RESET_VECTOR(16'h0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .mem_req                 (mem_req),
        .mem_addr                (mem_addr),
        .mem_ack                 (mem_ack),
        .mem_rdata               (mem_rdata),
        .instr_valid             (instr_valid),
        .instruction             (instruction),
        .peek_jump_address       (peek_jump_address),
        .program_counter_address (program_counter_address),
        .advance                 (advance),
        .new_address             (new_address)
`ifdef FETCH_ALIGN_FAULT_EN
        ,
        .align_fault             (align_fault)
`endif
    );

    // Memory model: word array, wait_cfg idle cycles before each ack, garbage
    // on mem_rdata whenever ack is low. Acked addresses are logged.
    bit   [15:0] mem [0:32767];
    int          wait_cfg = 0;
    int          wait_cnt;
    logic [15:0] ack_addr_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ack   <= 1'b0;
            mem_rdata <= 16'h0000;
            wait_cnt  <= 0;
        end else if (mem_req && !mem_ack) begin
            if (wait_cnt < wait_cfg) begin
                wait_cnt  <= wait_cnt + 1;
                mem_ack   <= 1'b0;
                mem_rdata <= 16'($urandom);
            end else begin
                wait_cnt  <= 0;
                mem_ack   <= 1'b1;
                mem_rdata <= mem[mem_addr[15:1]];
                ack_addr_q.push_back(mem_addr);
            end
        end else begin
            wait_cnt  <= 0;
            mem_ack   <= 1'b0;
            mem_rdata <= 16'($urandom);
        end
    end

    // {count, first, second} of the acked address log.
    function automatic logic [47:0] ack_log();
        logic [15:0] a0, a1;
        a0 = (ack_addr_q.size() > 0) ? ack_addr_q[0] : 16'h0000;
        a1 = (ack_addr_q.size() > 1) ? ack_addr_q[1] : 16'h0000;
        return {16'(ack_addr_q.size()), a0, a1};
    endfunction

    // Retire from READY; returns at the negedge after the retire edge.
    task automatic do_advance(input logic [15:0] addr);
        ack_addr_q.delete();
        advance     = 1'b1;
        new_address = addr;
        @(negedge clk);
        advance     = 1'b0;
        new_address = 16'($urandom);
    endtask

    // Cycles until instr_valid, bounded (an expired bound shows as latency 200).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!instr_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        vectors++;
        if ({mem_req, mem_addr, instr_valid, instruction, peek_jump_address,
             program_counter_address} !== 66'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: req=%b addr=%h v=%b ins=%h peek=%h pca=%h, required all 0",
                     mem_req, mem_addr, instr_valid, instruction, peek_jump_address,
                     program_counter_address);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_held_req: got %b required 0", mem_req);
        end
    endtask

    task automatic test_single_word();
        int lat;
        mem[0]   = 16'h0A12;
        wait_cfg = 0;
        ack_addr_q.delete();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
            miscompares++;
            $display("FAIL first_req: req=%b addr=%h required 1/0000", mem_req, mem_addr);
        end
        wait_valid(lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL single_latency: got %0d required 2", lat);
        end
        vectors++;
        if ({instruction, peek_jump_address, program_counter_address} !== {16'h0A12, 16'h0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL single_fields: ins=%h peek=%h pca=%h required 0a12/0000/0000",
                     instruction, peek_jump_address, program_counter_address);
        end
    endtask

    task automatic test_jump();
        int lat;
        mem[1]    = 16'h1400;
        mem[2]    = 16'h0040;
        mem[16'h20] = 16'h0B00;
        do_advance(16'h0002);
        wait_valid(lat);
        vectors++;
        if (lat !== 4) begin
            miscompares++;
            $display("FAIL jump_latency: got %0d required 4", lat);
        end
        vectors++;
        if (ack_log() !== {16'd2, 16'h0002, 16'h0004}) begin
            miscompares++;
            $display("FAIL jump_requests: got %h required 0002_0002_0004", ack_log());
        end
        vectors++;
        if ({instruction, peek_jump_address, program_counter_address} !== {16'h1400, 16'h0040, 16'h0004}) begin
            miscompares++;
            $display("FAIL jump_fields: ins=%h peek=%h pca=%h required 1400/0040/0004",
                     instruction, peek_jump_address, program_counter_address);
        end
    endtask

    task automatic test_wait_states();
        int lat;
        wait_cfg = 3;
        do_advance(16'h0040);
        vectors++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0040}) begin
            miscompares++;
            $display("FAIL jump_target_req: req=%b addr=%h required 1/0040", mem_req, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({mem_req, mem_addr, instr_valid} !== {1'b1, 16'h0040, 1'b0}) begin
                miscompares++;
                $display("FAIL wait_hold[%0d]: req=%b addr=%h v=%b required 1/0040/0",
                         i, mem_req, mem_addr, instr_valid);
            end
        end
        wait_valid(lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL wait_latency: got %0d more cycles required 2", lat);
        end
        vectors++;
        if ({instruction, program_counter_address} !== {16'h0B00, 16'h0040}) begin
            miscompares++;
            $display("FAIL wait_fields: ins=%h pca=%h required 0b00/0040",
                     instruction, program_counter_address);
        end
    endtask

    task automatic test_advance_ignored();
        int lat;
        mem[16'h80] = 16'h0C34;
        wait_cfg    = 2;
        do_advance(16'h0100);
        advance     = 1'b1;
        new_address = 16'h1234;
        repeat (2) @(negedge clk);
        advance     = 1'b0;
        vectors++;
        if (mem_addr !== 16'h0100) begin
            miscompares++;
            $display("FAIL ignored_addr: got %h required 0100", mem_addr);
        end
        wait_valid(lat);
        vectors++;
        if (lat !== 2) begin
            miscompares++;
            $display("FAIL ignored_latency: got %0d required 2", lat);
        end
        vectors++;
        if ({instruction, program_counter_address, ack_log()} !==
            {16'h0C34, 16'h0100, 16'd1, 16'h0100, 16'h0000}) begin
            miscompares++;
            $display("FAIL ignored_fields: ins=%h pca=%h log=%h required 0c34/0100/0001_0100_0000",
                     instruction, program_counter_address, ack_log());
        end
    endtask

    task automatic test_wrap();
        int lat;
        mem[16'h7FFF] = 16'h2000;
        wait_cfg      = 0;
        do_advance(16'hFFFE);
        wait_valid(lat);
        vectors++;
        if ({ack_log(), instruction, peek_jump_address, program_counter_address} !==
            {16'd2, 16'hFFFE, 16'h0000, 16'h2000, 16'h0A12, 16'h0000}) begin
            miscompares++;
            $display("FAIL wrap: log=%h ins=%h peek=%h pca=%h required 0002_fffe_0000/2000/0a12/0000",
                     ack_log(), instruction, peek_jump_address, program_counter_address);
        end
    endtask

    task automatic test_mid_fetch_reset();
        int lat;
        wait_cfg = 4;
        do_advance(16'h0200);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({mem_req, mem_addr, instr_valid, instruction} !== 34'd0) begin
            miscompares++;
            $display("FAIL midreset_async: req=%b addr=%h v=%b ins=%h required all 0",
                     mem_req, mem_addr, instr_valid, instruction);
        end
        @(negedge clk);
        wait_cfg = 0;
        ack_addr_q.delete();
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
            miscompares++;
            $display("FAIL midreset_restart: req=%b addr=%h required 1/0000", mem_req, mem_addr);
        end
        wait_valid(lat);
        vectors++;
        if ({instruction, ack_log()} !== {16'h0A12, 16'd1, 16'h0000, 16'h0000}) begin
            miscompares++;
            $display("FAIL midreset_fetch: ins=%h log=%h required 0a12/0001_0000_0000",
                     instruction, ack_log());
        end
    endtask

    task automatic test_alignment();
        int lat;
        mem[9] = 16'h0D00;
        do_advance(16'h0013);
`ifdef FETCH_ALIGN_FAULT_EN
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({align_fault, mem_req, instr_valid} !== 3'b100) begin
                miscompares++;
                $display("FAIL align_fault[%0d]: fault=%b req=%b v=%b required 1/0/0",
                         i, align_fault, mem_req, instr_valid);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_valid(lat);
        vectors++;
        if ({align_fault, instruction, lat[7:0]} !== {1'b0, 16'h0A12, 8'd2}) begin
            miscompares++;
            $display("FAIL align_recover: fault=%b ins=%h lat=%0d required 0/0a12/2",
                     align_fault, instruction, lat);
        end
`else
        vectors++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0012}) begin
            miscompares++;
            $display("FAIL align_clear: req=%b addr=%h required 1/0012", mem_req, mem_addr);
        end
        wait_valid(lat);
        vectors++;
        if ({instruction, program_counter_address} !== {16'h0D00, 16'h0012}) begin
            miscompares++;
            $display("FAIL align_fields: ins=%h pca=%h required 0d00/0012",
                     instruction, program_counter_address);
        end
`endif
    endtask

    // Random programs: each step writes a fresh instruction (and target for
    // jumps) at a random address, retires to it and checks the result.
    task automatic test_random();
        int          lat;
        int          w;
        int          exp_lat;
        logic [15:0] drive, pc, tgt_addr, op, tgt, exp_peek, exp_pca;
        logic [7:0]  hi;
        logic        jmp;
        for (int i = 0; i < 40; i++) begin
            drive = 16'($urandom);
`ifdef FETCH_ALIGN_FAULT_EN
            drive[0] = 1'b0;
`endif
            pc       = {drive[15:1], 1'b0};
            tgt_addr = pc + 16'd2;
            w        = $urandom_range(0, 3);
            jmp      = ($urandom_range(0, 2) == 0);
            if (jmp) begin
                hi = 8'($urandom_range(8'h14, 8'h24));
            end else begin
                hi = 8'($urandom);
                if (hi >= 8'h14 && hi <= 8'h24) hi = hi ^ 8'h80;
            end
            op  = {hi, 8'($urandom)};
            tgt = 16'($urandom);
            mem[pc[15:1]] = op;
            if (jmp) mem[tgt_addr[15:1]] = tgt;
            exp_peek = jmp ? tgt : 16'h0000;
            exp_pca  = jmp ? tgt_addr : pc;
            exp_lat  = jmp ? 4 + 2 * w : 2 + w;
            wait_cfg = w;
            do_advance(drive);
            wait_valid(lat);
            vectors++;
            if (lat !== exp_lat) begin
                miscompares++;
                $display("FAIL rand_latency[%0d]: got %0d required %0d", i, lat, exp_lat);
            end
            vectors++;
            if ({instruction, peek_jump_address, program_counter_address} !== {op, exp_peek, exp_pca}) begin
                miscompares++;
                $display("FAIL rand_fields[%0d]: ins=%h peek=%h pca=%h required %h/%h/%h",
                         i, instruction, peek_jump_address, program_counter_address, op, exp_peek, exp_pca);
            end
            vectors++;
            if (ack_log() !== {jmp ? 16'd2 : 16'd1, pc, jmp ? tgt_addr : 16'h0000}) begin
                miscompares++;
                $display("FAIL rand_requests[%0d]: got %h pc=%h jump=%b", i, ack_log(), pc, jmp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_jump();
        test_wait_states();
        test_advance_ignored();
        test_wrap();
        test_mid_fetch_reset();
        test_alignment();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
